bar_port_arbiter: RTL and testbench

Round-robin arbiter that shares one bar SRAM port among up to `NREQ` compute engines (linear, qkmm, softmax, attmm, pool) so engines can overlap on a bar instead of being statically muxed by stage. It sits between the engines' bar ports and one bar of `mhsa_acc_top`, with one instance per bar. It grants one access per cycle, supports locked bursts with a fairness cap, and routes read data back to the issuing requester after the fixed SRAM read latency.

---
 rtl/mhsa_pkg.sv | 11 +
 rtl/bar_port_arbiter_if.sv | 17 +
 rtl/rr_pick.sv | 24 ++
 rtl/bar_port_arbiter.sv | 86 ++++++++
 tb/tb_bar_port_arbiter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mhsa_pkg.sv
// mhsa_pkg: shared bar-port types and constants for the MHSA accelerator.
package mhsa_pkg;
  localparam int BAR_AW = 32;
  localparam int BAR_DW = 64;
  typedef struct packed {
    logic              we;
    logic [BAR_AW-1:0] addr;
    logic [BAR_DW-1:0] wdata;
  } bar_req_t;
  typedef enum logic {ARB, HOLD} arb_state_e;
endpackage

// File: rtl/bar_port_arbiter_if.sv
// bar_port_arbiter_if: engine-side bar request/grant/read-return bundle.
interface bar_port_arbiter_if #(
  parameter int WIDTH = 64,
  parameter int NREQ  = 4
);
  import mhsa_pkg::*;
  logic [NREQ-1:0]             req;
  logic [NREQ-1:0]             lock;
  logic [NREQ-1:0]             we;
  logic [NREQ-1:0][BAR_AW-1:0] addr;
  logic [NREQ-1:0][WIDTH-1:0]  wdata;
  logic [NREQ-1:0]             gnt;
  logic [NREQ-1:0]             rvalid;
  logic [WIDTH-1:0]            rdata;
  modport master (output req, lock, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave (input req, lock, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority one-hot picker, priority starts at ptr.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    int j;
    idx = '0;
    // scan lowest priority first so the highest-priority hit is written last
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      j = j >= N ? j - N : j;
      idx = req[j] ? IW'(j) : idx;
    end
    any = |req;
    onehot = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/bar_port_arbiter.sv
// bar_port_arbiter: round-robin sharing of one bar SRAM port with locked bursts and read-data return.
module bar_port_arbiter
  import mhsa_pkg::*;
#(
  parameter int WIDTH     = BAR_DW,
  parameter int NREQ      = 4,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  bar_port_arbiter_if.slave bus,
  output logic              busy,
  output logic              bar_write_en,
  output logic [WIDTH-1:0]  bar_data_in,
  output logic [BAR_AW-1:0] bar_addr,
  input  logic [WIDTH-1:0]  bar_data_out
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  arb_state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, own_q, own_d, w, pick_idx;
  logic [CW-1:0] bcnt_q, bcnt_d, cnt_n;
  logic [NREQ-1:0] pick_oh;
  logic pick_any, hold_act, fire, rel;
  bar_req_t sel;
  logic [RD_LAT-1:0] pv;
  logic [RD_LAT-1:0][IW-1:0] pi;
  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req(bus.req), .ptr(ptr_q), .onehot(pick_oh), .idx(pick_idx), .any(pick_any)
  );
  always_comb begin
    hold_act = state_q == HOLD && bus.req[own_q];
    w = hold_act ? own_q : pick_idx;
    fire = rst_n && en && (hold_act || pick_any);
    cnt_n = (hold_act ? bcnt_q : '0) + CW'(1);
    // the MAX_BURST-th grant still goes to the owner; ownership ends at that edge
    rel = !(bus.lock[w] && cnt_n < CW'(MAX_BURST));
    state_d = state_q;
    own_d = own_q;
    bcnt_d = bcnt_q;
    ptr_d = ptr_q;
    if (fire) begin
      state_d = rel ? ARB : HOLD;
      own_d = w;
      bcnt_d = rel ? '0 : cnt_n;
      ptr_d = rel ? (w == IW'(NREQ - 1) ? '0 : w + IW'(1)) : ptr_q;
    end else if (en && state_q == HOLD) begin
      state_d = ARB;
      bcnt_d = '0;
    end
    bus.gnt = fire ? (hold_act ? NREQ'(1) << own_q : pick_oh) : '0;
    sel = fire ? bar_req_t'{we: bus.we[w], addr: bus.addr[w], wdata: BAR_DW'(bus.wdata[w])} : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ARB;
      ptr_q <= '0;
      own_q <= '0;
      bcnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
      bcnt_q <= bcnt_d;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pv <= '0;
      pi <= '0;
    end else begin
      pv[0] <= fire && !bus.we[w];
      pi[0] <= w;
      for (int k = 1; k < RD_LAT; k++) begin
        pv[k] <= pv[k-1];
        pi[k] <= pi[k-1];
      end
    end
  assign bus.rvalid = pv[RD_LAT-1] ? NREQ'(1) << pi[RD_LAT-1] : '0;
  assign bus.rdata = pv[RD_LAT-1] ? bar_data_out : '0;
  assign busy = |pv || state_q == HOLD;
  assign bar_write_en = sel.we;
  assign bar_addr = sel.addr;
  assign bar_data_in = sel.wdata[WIDTH-1:0];
endmodule

// File: tb/tb_bar_port_arbiter.sv
// tb_bar_port_arbiter: vector table, directed corner cases and a random run against a behavioural model.
module tb_bar_port_arbiter;
  localparam int N = 4, W = 64, MB = 16;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic busy1, wen1, busy3, wen3;
  logic [W-1:0] din1, dout1, din3, dout3;
  logic [31:0] a1, a3;
  always #5 clk = ~clk;
  bar_port_arbiter_if #(.WIDTH(W), .NREQ(N)) b1 ();
  bar_port_arbiter_if #(.WIDTH(W), .NREQ(N)) b3 ();
  bar_port_arbiter #(.WIDTH(W), .NREQ(N), .RD_LAT(1), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(b1), .busy(busy1), .bar_write_en(wen1),
    .bar_data_in(din1), .bar_addr(a1), .bar_data_out(dout1)
  );
  bar_port_arbiter #(.WIDTH(W), .NREQ(N), .RD_LAT(3), .MAX_BURST(MB)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .bus(b3), .busy(busy3), .bar_write_en(wen3),
    .bar_data_in(din3), .bar_addr(a3), .bar_data_out(dout3)
  );
  typedef struct {int due; int idx;} rd_t;
  rd_t q[$];
  int m_ptr, m_own, m_cnt, win, cyc_n, n_chk, n_fail;
  typedef struct {
    logic en; logic [3:0] req, we, exp_gnt, exp_rv; logic exp_wen; logic [31:0] exp_addr;
  } vec_t;
  vec_t tbl[13];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc_n, act, exp);
    end
  endtask
  task automatic model_clear();
    m_ptr = 0; m_own = -1; m_cnt = 0;
    q.delete();
  endtask
  // expected outputs from the arbitration rules: owner first, else first requester from ptr
  task automatic mid();
    logic [N-1:0] eg, erv;
    logic [63:0] erd, ewd;
    logic ewe;
    logic [31:0] ea;
    @(negedge clk);
    if (!rst_n) model_clear();
    win = -1;
    if (rst_n && en) begin
      if (m_own >= 0 && b1.req[m_own]) win = m_own;
      else for (int k = 0; k < N; k++) if (win < 0 && b1.req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    end
    eg = '0; ewe = 1'b0; ea = '0; ewd = '0;
    if (win >= 0) begin
      eg[win] = 1'b1; ewe = b1.we[win]; ea = b1.addr[win]; ewd = b1.wdata[win];
    end
    erv = '0; erd = '0;
    foreach (q[i]) if (q[i].due == cyc_n) begin erv[q[i].idx] = 1'b1; erd = dout1; end
    chk("gnt", b1.gnt, eg);
    chk("bar_write_en", wen1, ewe);
    chk("bar_addr", a1, ea);
    chk("bar_data_in", din1, ewd);
    chk("rvalid", b1.rvalid, erv);
    chk("rdata", b1.rdata, erd);
    chk("busy", busy1, q.size() > 0 || m_own >= 0);
  endtask
  task automatic adv();
    @(posedge clk);
    while (q.size() > 0 && q[0].due <= cyc_n) void'(q.pop_front());
    if (rst_n && en) begin
      if (win >= 0) begin
        m_cnt = win == m_own ? m_cnt + 1 : 1;
        if (b1.lock[win] && m_cnt < MB) m_own = win;
        else begin m_own = -1; m_cnt = 0; m_ptr = (win + 1) % N; end
        if (!b1.we[win]) q.push_back('{due: cyc_n + 1, idx: win});
      end else begin
        m_own = -1; m_cnt = 0;
      end
    end
    cyc_n++;
    #1;
    dout1 = {$urandom, $urandom};
    dout3 = {$urandom, $urandom};
  endtask
  task automatic cyc();
    mid();
    adv();
  endtask
  initial begin
    n_chk = 0; n_fail = 0; cyc_n = 0;
    model_clear();
    dout1 = 64'h1; dout3 = 64'h3;
    b1.req = 4'hF; b1.lock = '0; b1.we = '0; b1.addr = '0; b1.wdata = '0;
    b3.req = '0; b3.lock = '0; b3.we = '0; b3.addr = '0; b3.wdata = '0;
    en = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b1;
    b1.req = '0;
    for (int i = 0; i < N; i++) begin
      b1.addr[i] = 32'h1000 + i;
      b1.wdata[i] = {$urandom, $urandom};
    end
    b1.addr[1] = 32'h10;
    b1.wdata[1] = 64'hA5;
    tbl = '{
      '{1'b1, 4'hF, 4'h0, 4'h1, 4'h0, 1'b0, 32'h1000},
      '{1'b1, 4'hF, 4'h0, 4'h2, 4'h1, 1'b0, 32'h10},
      '{1'b1, 4'hF, 4'h0, 4'h4, 4'h2, 1'b0, 32'h1002},
      '{1'b1, 4'hF, 4'h0, 4'h8, 4'h4, 1'b0, 32'h1003},
      '{1'b1, 4'hF, 4'h0, 4'h1, 4'h8, 1'b0, 32'h1000},
      '{1'b1, 4'hF, 4'h0, 4'h2, 4'h1, 1'b0, 32'h10},
      '{1'b1, 4'hF, 4'h0, 4'h4, 4'h2, 1'b0, 32'h1002},
      '{1'b1, 4'hF, 4'h0, 4'h8, 4'h4, 1'b0, 32'h1003},
      '{1'b1, 4'hA, 4'h2, 4'h2, 4'h8, 1'b1, 32'h10},
      '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0},
      '{1'b1, 4'h8, 4'h0, 4'h8, 4'h0, 1'b0, 32'h1003},
      '{1'b0, 4'hF, 4'h0, 4'h0, 4'h8, 1'b0, 32'h0},
      '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0}
    };
    foreach (tbl[i]) begin
      en = tbl[i].en; b1.req = tbl[i].req; b1.we = tbl[i].we;
      mid();
      chk("tbl_gnt", b1.gnt, tbl[i].exp_gnt);
      chk("tbl_rvalid", b1.rvalid, tbl[i].exp_rv);
      chk("tbl_wen", wen1, tbl[i].exp_wen);
      chk("tbl_addr", a1, tbl[i].exp_addr);
      adv();
    end
    // locked burst by 2 hits the cap, then 0 wins from ptr=3
    b1.req = 4'h1; b1.we = '0; b1.lock = '0;
    cyc();
    b1.req = 4'h5; b1.lock = 4'h4;
    for (int k = 0; k < MB; k++) begin
      mid();
      chk("burst_gnt", b1.gnt, 4'h4);
      adv();
    end
    mid();
    chk("release_gnt", b1.gnt, 4'h1);
    adv();
    // owner drops req while another requests: same-cycle rearbitration
    b1.req = 4'h6; b1.lock = 4'h2;
    mid();
    chk("lock1_gnt", b1.gnt, 4'h2);
    adv();
    b1.req = 4'h4; b1.lock = '0;
    mid();
    chk("drop_gnt", b1.gnt, 4'h4);
    adv();
    b1.req = '0;
    repeat (2) cyc();
    // read granted, then reset pulse: the read never returns
    b1.req = 4'h1;
    mid();
    chk("pre_rst_gnt", b1.gnt, 4'h1);
    adv();
    rst_n = 1'b0; b1.req = 4'hF;
    mid();
    chk("rst_gnt", b1.gnt, 4'h0);
    chk("rst_rvalid", b1.rvalid, 4'h0);
    chk("rst_busy", busy1, 1'b0);
    adv();
    rst_n = 1'b1; b1.req = '0;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("post_rst_rvalid", b1.rvalid, 4'h0);
      adv();
    end
    // three-cycle read latency instance
    for (int t = 0; t < 7; t++) begin
      b3.req = t < 3 ? 4'(1 << t) : 4'h0;
      mid();
      chk("lat3_gnt", b3.gnt, t < 3 ? 4'(1 << t) : 4'h0);
      chk("lat3_rvalid", b3.rvalid, (t >= 3 && t <= 5) ? 4'(1 << (t - 3)) : 4'h0);
      chk("lat3_rdata", b3.rdata, (t >= 3 && t <= 5) ? dout3 : 64'h0);
      adv();
    end
    b3.req = '0;
    for (int i = 0; i < 400; i++) begin
      rst_n = $urandom_range(0, 99) != 0;
      en = $urandom_range(0, 9) != 0;
      if ((i / 100) % 2 == 1) begin
        b1.req = 4'hF;
        b1.lock = $urandom_range(0, 9) != 0 ? 4'hF : 4'($urandom);
      end else begin
        b1.req = 4'($urandom | $urandom);
        b1.lock = 4'($urandom);
      end
      b1.we = 4'($urandom & $urandom);
      for (int k = 0; k < N; k++) begin
        b1.addr[k] = $urandom;
        b1.wdata[k] = {$urandom, $urandom};
      end
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
